// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M funct3 encodings and FSM state constants shared by the mul/div unit
package muldiv_pkg;
   typedef logic [2:0] op_t;
   localparam op_t OP_MUL    = 3'd0;
   localparam op_t OP_MULH   = 3'd1;
   localparam op_t OP_MULHSU = 3'd2;
   localparam op_t OP_MULHU  = 3'd3;
   localparam op_t OP_DIV    = 3'd4;
   localparam op_t OP_DIVU   = 3'd5;
   localparam op_t OP_REM    = 3'd6;
   localparam op_t OP_REMU   = 3'd7;
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_CALC = 2'd1;
   localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit (valid/ready request in, valid/ready result out with tag, flush, busy stall)
module ex_muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int TAGW = 5
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            req_valid_i,
   output logic            req_ready_o,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] data1_i,
   input  logic [XLEN-1:0] data2_i,
   input  logic [TAGW-1:0] RDaddr_i,
   input  logic            flush_i,
   output logic            resp_valid_o,
   input  logic            resp_ready_i,
   output logic [XLEN-1:0] data_o,
   output logic [TAGW-1:0] RDaddr_o,
   output logic            busy_o
);
   localparam int CW = $clog2(XLEN) + 1;
   state_t            state;
   logic [CW-1:0]     cnt;
   op_t               op_q;
   logic              neg_q, neg_r, spec_q;
   logic [XLEN-1:0]   hi, lo, bm;
   logic [TAGW-1:0]   tag_q;
   logic              sa, sb, na, nb, div0, ovf, dge;
   logic [XLEN-1:0]   ma, mb, spec_res, hi_n, lo_n, quot, remv, res;
   logic [XLEN:0]     msum, drem, ddif;
   logic [2*XLEN-1:0] prod_c;
   assign req_ready_o  = state == ST_IDLE;
   assign resp_valid_o = state == ST_DONE;
   assign busy_o       = state != ST_IDLE;
   always_comb begin
      sa = op_i == OP_MULH || op_i == OP_MULHSU || op_i == OP_DIV || op_i == OP_REM;
      sb = op_i == OP_MULH || op_i == OP_DIV || op_i == OP_REM;
      na = sa & data1_i[XLEN-1];
      nb = sb & data2_i[XLEN-1];
      ma = na ? -data1_i : data1_i;
      mb = nb ? -data2_i : data2_i;
      div0 = op_i[2] && data2_i == '0;
      ovf = (op_i == OP_DIV || op_i == OP_REM) && data1_i == {1'b1, {(XLEN-1){1'b0}}} && data2_i == '1;
      // op_i[1] separates REM/REMU from DIV/DIVU within the divide group
      spec_res = div0 ? (op_i[1] ? data1_i : '1) : (op_i[1] ? '0 : data1_i);
      // multiply: shift-add with {hi,lo} as the product and lo as the multiplier
      msum = {1'b0, hi} + (lo[0] ? {1'b0, bm} : '0);
      // divide: restoring step, hi is the partial remainder, lo shifts dividend out and quotient in
      drem = {hi, lo[XLEN-1]};
      dge  = drem >= {1'b0, bm};
      ddif = drem - {1'b0, bm};
      hi_n = op_q[2] ? (dge ? ddif[XLEN-1:0] : drem[XLEN-1:0]) : msum[XLEN:1];
      lo_n = op_q[2] ? {lo[XLEN-2:0], dge} : {msum[0], lo[XLEN-1:1]};
      prod_c = neg_q ? -{hi, lo} : {hi, lo};
      quot = neg_q ? -lo : lo;
      remv = neg_r ? -hi : hi;
      res = spec_q ? lo : op_q[2] ? (op_q[1] ? remv : quot) :
            op_q == OP_MUL ? prod_c[XLEN-1:0] : prod_c[2*XLEN-1:XLEN];
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         data_o   <= '0;
         RDaddr_o <= '0;
         op_q     <= OP_MUL;
         tag_q    <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         spec_q   <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         bm       <= '0;
      end else if (flush_i) begin
         state <= ST_IDLE;
      end else if (state == ST_IDLE) begin
         if (req_valid_i) begin
            state  <= ST_CALC;
            op_q   <= op_i;
            tag_q  <= RDaddr_i;
            neg_q  <= na ^ nb;
            neg_r  <= na;
            spec_q <= div0 | ovf;
            hi     <= '0;
            lo     <= (div0 | ovf) ? spec_res : ma;
            bm     <= mb;
            cnt    <= (div0 | ovf) ? '0 : CW'(XLEN);
         end
      end else if (state == ST_CALC) begin
         if (cnt == '0) begin
            state    <= ST_DONE;
            data_o   <= res;
            RDaddr_o <= tag_q;
         end else begin
            hi  <= hi_n;
            lo  <= lo_n;
            cnt <= cnt - 1'b1;
         end
      end else if (resp_ready_i) begin
         state <= ST_IDLE;
      end
   end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed self-checking bench for ex_muldiv_unit at XLEN=32
module tb_ex_muldiv_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_ready, flush = 1'b0;
   logic        resp_valid, resp_ready = 1'b0, busy;
   logic [2:0]  op = 3'd0;
   logic [31:0] d1 = '0, d2 = '0, dout;
   logic [4:0]  rd_in = '0, rd_out;
   int          checks = 0, errors = 0;
   always #5 clk = ~clk;
   ex_muldiv_unit #(.XLEN(32), .TAGW(5)) dut (
      .clk_i(clk), .rst_i(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
      .op_i(op), .data1_i(d1), .data2_i(d2), .RDaddr_i(rd_in), .flush_i(flush),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .data_o(dout),
      .RDaddr_o(rd_out), .busy_o(busy)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
      req_valid = 1'b1; op = o; d1 = a; d2 = b; rd_in = t;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask
   task automatic wait_resp(output int n);
      n = 0;
      while (!resp_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
   endtask
   task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] t, input logic [31:0] exp, input int lat);
      int n;
      issue(o, a, b, t);
      wait_resp(n);
      chk({name, "_lat"}, n, lat);
      chk({name, "_data"}, dout, exp);
      chk({name, "_tag"}, rd_out, t);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk({name, "_idle"}, req_ready, 1);
   endtask
   initial begin
      int  n;
      logic seen;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", req_ready, 1);
      chk("rst_valid", resp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_data", dout, 0);
      chk("rst_tag", rd_out, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("mul_7x-3",   3'd0, 32'd7, 32'hFFFFFFFD, 5'd3, 32'hFFFFFFEB, 33);
      run_op("mul_shift",  3'd0, 32'h12345678, 32'h10, 5'd4, 32'h23456780, 33);
      run_op("mulhu_ff",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5, 32'hFFFFFFFE, 33);
      run_op("mulh_ff",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'h00000000, 33);
      run_op("mulhsu_ff",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7, 32'hFFFFFFFF, 33);
      run_op("div_-7_2",   3'd4, 32'hFFFFFFF9, 32'd2, 5'd17, 32'hFFFFFFFD, 33);
      run_op("rem_-7_2",   3'd6, 32'hFFFFFFF9, 32'd2, 5'd18, 32'hFFFFFFFF, 33);
      run_op("div_7_-2",   3'd4, 32'd7, 32'hFFFFFFFE, 5'd19, 32'hFFFFFFFD, 33);
      run_op("rem_7_-2",   3'd6, 32'd7, 32'hFFFFFFFE, 5'd20, 32'd1, 33);
      run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd21, 32'd14, 33);
      run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd22, 32'd2, 33);
      run_op("divu_5_0",   3'd5, 32'd5, 32'd0, 5'd23, 32'hFFFFFFFF, 1);
      run_op("rem_5_0",    3'd6, 32'd5, 32'd0, 5'd24, 32'd5, 1);
      run_op("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd25, 32'h80000000, 1);
      run_op("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd26, 32'd0, 1);
      issue(3'd0, 32'd6, 32'd7, 5'd9);
      wait_resp(n);
      chk("stall_lat", n, 33);
      repeat (4) begin
         @(posedge clk); #1;
         chk("stall_data", dout, 42);
         chk("stall_tag", rd_out, 9);
         chk("stall_busy", busy, 1);
         chk("stall_valid", resp_valid, 1);
      end
      resp_ready = 1'b1; req_valid = 1'b1; op = 3'd0; d1 = 32'd2; d2 = 32'd2;
      @(posedge clk); #1;
      resp_ready = 1'b0; req_valid = 1'b0;
      chk("release_ready", req_ready, 1);
      chk("release_noacc", busy, 0);
      @(posedge clk); #1;
      chk("release_idle", busy, 0);
      req_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0; flush = 1'b0;
      chk("flush_vs_acc", busy, 0);
      issue(3'd0, 32'd3, 32'd3, 5'd11);
      repeat (10) @(posedge clk);
      #1;
      chk("flush_pre_busy", busy, 1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_ready", req_ready, 1);
      chk("flush_valid", resp_valid, 0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen |= resp_valid;
      end
      chk("flush_noresp", seen, 0);
      issue(3'd4, 32'hFFFFFF9C, 32'd3, 5'd12);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_ready", req_ready, 1);
      chk("arst_busy", busy, 0);
      chk("arst_data", dout, 0);
      chk("arst_tag", rd_out, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         seen |= resp_valid;
      end
      chk("arst_noresp", seen, 0);
      run_op("div_-100_3", 3'd4, 32'hFFFFFF9C, 32'd3, 5'd13, 32'hFFFFFFDF, 33);
      run_op("rem_-100_3", 3'd6, 32'hFFFFFF9C, 32'd3, 5'd14, 32'hFFFFFFFF, 33);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
